// File: rtl/led_remote_pkg.sv
// Shared encodings for the LED remote: debouncer states, controller states, step request.
package led_remote_pkg;

  localparam logic [1:0] BTN_IDLE  = 2'd0;
  localparam logic [1:0] BTN_WAIT  = 2'd1;
  localparam logic [1:0] BTN_PRESS = 2'd2;
  localparam logic [1:0] BTN_HELD  = 2'd3;

  typedef enum logic [1:0] {
    CTL_IDLE = 2'd0,
    CTL_UP   = 2'd1,
    CTL_DOWN = 2'd2
  } ctl_state_e;

  typedef struct packed {
    logic up;
    logic dn;
  } step_req_t;

  // Pressed or held: the owning button is still down.
  function automatic logic btn_active(logic [1:0] st);
    return (st == BTN_PRESS) || (st == BTN_HELD);
  endfunction

endpackage

// File: rtl/led_pwm.sv
// PWM stage: free-running counter 0..MAX_LEVEL-1 with a registered level comparator.
module led_pwm #(
  parameter int LW        = 4,
  parameter int MAX_LEVEL = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [LW-1:0] level,
  output logic          pwm_out
);

  localparam logic [LW-1:0] CNT_LAST = LW'(MAX_LEVEL - 1);

  logic [LW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic          pwm_out_q, pwm_out_d;

  always_comb begin
    pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + 1'b1;
    pwm_out_d = (pwm_cnt_q < level);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      pwm_out_q <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;

endmodule

// File: rtl/led_level_controller.sv
// Button ownership FSM, hold/auto-repeat timing and LED level register feeding led_pwm.
// Define LEVEL_WRAP_EN to wrap the level at its ends instead of saturating.
module led_level_controller
  import led_remote_pkg::*;
#(
  parameter int LW         = 4,
  parameter int MAX_LEVEL  = 15,
  parameter int INIT_LEVEL = 8,
  parameter int HOLD_DLY   = 25000000,
  parameter int RPT_PER    = 5000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    up_st,
  input  logic [1:0]    down_st,
  output logic [LW-1:0] level,
  output logic          step_pulse,
  output logic          at_max,
  output logic          at_min,
  output logic          pwm_out
);

  localparam logic [LW-1:0] MAX_L     = LW'(MAX_LEVEL);
  localparam logic [LW-1:0] INIT_L    = LW'(INIT_LEVEL);
  localparam logic [31:0]   HOLD_LAST = 32'(HOLD_DLY - 1);
  localparam logic [31:0]   RELOAD    = 32'(HOLD_DLY - RPT_PER);

  ctl_state_e    state_q, state_d;
  logic [31:0]   hold_cnt_q, hold_cnt_d;
  logic [LW-1:0] level_q, level_d;
  logic          step_pulse_q, step_pulse_d;
  step_req_t     step;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    step       = '0;
    unique case (state_q)
      CTL_IDLE: begin
        hold_cnt_d = '0;
        if (up_st == BTN_PRESS && down_st != BTN_PRESS) begin
          step.up = 1'b1;
          state_d = CTL_UP;
        end else if (down_st == BTN_PRESS && up_st != BTN_PRESS) begin
          step.dn = 1'b1;
          state_d = CTL_DOWN;
        end
      end
      CTL_UP: begin
        if (btn_active(up_st)) begin
          // Reload below the hold threshold so later repeats land every RPT_PER cycles.
          if (hold_cnt_q == HOLD_LAST) begin
            step.up    = 1'b1;
            hold_cnt_d = RELOAD;
          end else begin
            hold_cnt_d = hold_cnt_q + 32'd1;
          end
        end else begin
          state_d    = CTL_IDLE;
          hold_cnt_d = '0;
        end
      end
      CTL_DOWN: begin
        if (btn_active(down_st)) begin
          if (hold_cnt_q == HOLD_LAST) begin
            step.dn    = 1'b1;
            hold_cnt_d = RELOAD;
          end else begin
            hold_cnt_d = hold_cnt_q + 32'd1;
          end
        end else begin
          state_d    = CTL_IDLE;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = CTL_IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    level_d      = level_q;
    step_pulse_d = 1'b0;
    if (step.up) begin
      if (level_q == MAX_L) begin
`ifdef LEVEL_WRAP_EN
        level_d      = '0;
        step_pulse_d = 1'b1;
`else
        level_d      = level_q;
`endif
      end else begin
        level_d      = level_q + 1'b1;
        step_pulse_d = 1'b1;
      end
    end else if (step.dn) begin
      if (level_q == '0) begin
`ifdef LEVEL_WRAP_EN
        level_d      = MAX_L;
        step_pulse_d = 1'b1;
`else
        level_d      = level_q;
`endif
      end else begin
        level_d      = level_q - 1'b1;
        step_pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CTL_IDLE;
      hold_cnt_q   <= '0;
      level_q      <= INIT_L;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      level_q      <= level_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign level      = level_q;
  assign step_pulse = step_pulse_q;
  assign at_max     = (level_q == MAX_L);
  assign at_min     = (level_q == '0);

  led_pwm #(
    .LW        (LW),
    .MAX_LEVEL (MAX_LEVEL)
  ) u_pwm (
    .clk     (clk),
    .rst_n   (rst_n),
    .level   (level_q),
    .pwm_out (pwm_out)
  );

endmodule

// File: tb/tb_led_level_controller.sv
// Directed bench for led_level_controller: vector table plus hold, reset, wrap and PWM sequences.
module tb_led_level_controller;

  localparam int LW = 3, MAXL = 7, INIT = 3, HOLD = 4, RPT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    up_st = 2'd0, down_st = 2'd0;
  logic [LW-1:0] level;
  logic          step_pulse, at_max, at_min, pwm_out;

  int total = 0;
  int bad   = 0;

  led_level_controller #(
    .LW(LW), .MAX_LEVEL(MAXL), .INIT_LEVEL(INIT), .HOLD_DLY(HOLD), .RPT_PER(RPT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .up_st(up_st), .down_st(down_st),
    .level(level), .step_pulse(step_pulse), .at_max(at_max), .at_min(at_min),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] up;
    logic [1:0] dn;
    int         lvl;
    logic       pls;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] u, input logic [1:0] d);
    up_st   = u;
    down_st = d;
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle async reset, checked before any clock edge, then released.
  task automatic do_reset(input string tag);
    #4;
    rst_n = 1'b0;
    #1;
    chk({tag, "_level"}, int'(level), INIT);
    chk({tag, "_pulse"}, int'(step_pulse), 0);
    chk({tag, "_pwm"}, int'(pwm_out), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Press then hold one button for n cycles; the model schedules steps at
  // cycle 0, HOLD, HOLD+RPT, ... and applies the end-of-range rule.
  task automatic hold_run(input logic is_up, input int n, input int start, output int fin);
    int  lvl;
    int  errs;
    bit  stp;
    logic pls;
    lvl  = start;
    errs = 0;
    for (int k = 0; k < n; k++) begin
      if (is_up) cyc((k == 0) ? 2'd2 : 2'd3, 2'd0);
      else       cyc(2'd0, (k == 0) ? 2'd2 : 2'd3);
      stp = (k == 0) || (k >= HOLD && ((k - HOLD) % RPT) == 0);
      pls = 1'b0;
      if (stp) begin
        if (is_up) begin
          if (lvl < MAXL) begin lvl++; pls = 1'b1; end
`ifdef LEVEL_WRAP_EN
          else begin lvl = 0; pls = 1'b1; end
`endif
        end else begin
          if (lvl > 0) begin lvl--; pls = 1'b1; end
`ifdef LEVEL_WRAP_EN
          else begin lvl = MAXL; pls = 1'b1; end
`endif
        end
      end
      if (int'(level) != lvl || step_pulse != pls) begin
        errs++;
        $display("FAIL hold_k%0d: level=%0d pulse=%0d expected level=%0d pulse=%0d",
                 k, level, step_pulse, lvl, pls);
      end
    end
    total++;
    if (errs != 0) bad++;
    cyc(2'd0, 2'd0);
    chk("hold_release_pulse", int'(step_pulse), 0);
    chk("hold_at_max", int'(at_max), int'(lvl == MAXL));
    chk("hold_at_min", int'(at_min), int'(lvl == 0));
    fin = lvl;
  endtask

  task automatic pwm_high(output int hi);
    hi = 0;
    repeat (8) cyc(2'd0, 2'd0);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (pwm_out) hi++;
    end
  endtask

  initial begin
    int lvl, hi, pc;

    vecs[0]  = '{2'd2, 2'd0, 4, 1'b1};  // tap up
    vecs[1]  = '{2'd3, 2'd0, 4, 1'b0};
    vecs[2]  = '{2'd3, 2'd0, 4, 1'b0};
    vecs[3]  = '{2'd0, 2'd0, 4, 1'b0};  // release -> idle
    vecs[4]  = '{2'd0, 2'd0, 4, 1'b0};
    vecs[5]  = '{2'd3, 2'd0, 4, 1'b0};  // held without press: ignored
    vecs[6]  = '{2'd0, 2'd3, 4, 1'b0};
    vecs[7]  = '{2'd0, 2'd2, 3, 1'b1};  // tap down
    vecs[8]  = '{2'd0, 2'd0, 3, 1'b0};
    vecs[9]  = '{2'd2, 2'd2, 3, 1'b0};  // simultaneous presses
    vecs[10] = '{2'd0, 2'd0, 3, 1'b0};
    vecs[11] = '{2'd2, 2'd0, 4, 1'b1};
    vecs[12] = '{2'd3, 2'd0, 4, 1'b0};
    vecs[13] = '{2'd3, 2'd2, 4, 1'b0};  // down press while up owns
    vecs[14] = '{2'd0, 2'd3, 4, 1'b0};
    vecs[15] = '{2'd0, 2'd0, 4, 1'b0};

    #8;
    do_reset("rst0");
    chk("rst0_at_max", int'(at_max), 0);
    chk("rst0_at_min", int'(at_min), 0);

    for (int i = 0; i < 16; i++) begin
      cyc(vecs[i].up, vecs[i].dn);
      chk($sformatf("vec%0d_level", i), int'(level), vecs[i].lvl);
      chk($sformatf("vec%0d_pulse", i), int'(step_pulse), int'(vecs[i].pls));
    end

    // Reset during an up hold aborts it; the still-held button is ignored afterwards.
    cyc(2'd2, 2'd0);
    chk("prehold_level", int'(level), 5);
    cyc(2'd3, 2'd0);
    cyc(2'd3, 2'd0);
    do_reset("rst_hold");
    pc = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(2'd3, 2'd0);
      if (step_pulse) pc++;
    end
    chk("post_rst_pulses", pc, 0);
    chk("post_rst_level", int'(level), INIT);
    cyc(2'd0, 2'd0);

    hold_run(1'b1, 11, INIT, lvl);
    chk("hold_up_final", lvl, MAXL);

    cyc(2'd2, 2'd0);
`ifdef LEVEL_WRAP_EN
    chk("wrap_level", int'(level), 0);
    chk("wrap_pulse", int'(step_pulse), 1);
    chk("wrap_at_min", int'(at_min), 1);
    lvl = 0;
`else
    chk("sat_level", int'(level), MAXL);
    chk("sat_pulse", int'(step_pulse), 0);
    chk("sat_at_max", int'(at_max), 1);
`endif
    cyc(2'd0, 2'd0);

    hold_run(1'b0, 18, lvl, lvl);
    chk("hold_dn_final", int'(level), 0);
    pwm_high(hi);
    chk("pwm_lvl0", hi, 0);

    hold_run(1'b1, 16, lvl, lvl);
    chk("hold_up7", int'(level), MAXL);
    pwm_high(hi);
    chk("pwm_lvl7", hi, 14);

    do_reset("rst_pwm");
    cyc(2'd0, 2'd2);
    cyc(2'd0, 2'd0);
    chk("pwm_setup_level", int'(level), 2);
    pwm_high(hi);
    chk("pwm_lvl2", hi, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
